fp_normalize_pack: RTL and testbench
====================================

// Module: fp_normalize_pack
// PURPOSE
//  Back end of the single-precision FP add/sub datapath. Accepts the raw, un-normalised
//  result of the fraction adder (sign, biased exponent, 25-bit mantissa with carry), then
//  normalises it iteratively, one bit per cycle: right shift on carry-out, left shift on
//  leading zeros, exponent adjusted per step. Packs IEEE-754 binary32 with overflow/underflow
//  flags. Reverse direction of the alignment shifter; valid/ready on both sides.
// PARAMETERS
//  EXP_W   8   exponent field width
//  FRAC_W  23  stored fraction width; mantissa input is FRAC_W+2 bits {carry, hidden, frac}
// PORTS
//  clk           in   1         rising-edge clock
//  rst_n         in   1         asynchronous, active-low reset
//  in_valid      in   1         input operand valid
//  in_ready      out  1         block can accept operand (high only in IDLE)
//  in_sign       in   1         result sign
//  in_exp        in   EXP_W     biased exponent before normalisation
//  in_mant       in   FRAC_W+2  {carry, hidden, fraction}, unsigned magnitude
//  out_valid     out  1         packed result valid (high only in DONE)
//  out_ready     in   1         consumer takes result
//  out_result    out  32        {sign, exp[7:0], frac[22:0]}
//  out_overflow  out  1         result saturated to +/-inf
//  out_underflow out  1         result denormal (exp field 0, nonzero frac)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; out_result=0; flags=0;
//    internal regs cleared. Reset mid-operation aborts; the in-flight operand is discarded.
//  - FSM IDLE -> NORM -> DONE -> IDLE. No overlap: one operand in flight at a time.
//  - IDLE: in_valid&in_ready at edge T latches sign/exp/mant, -> NORM.
//  - NORM, exactly one action per cycle, checked in this priority order:
//    1 mant==0: result {sign,31'b0}, flags 0, -> DONE.
//    2 in_exp==0 or 255 (latched at accept): pass-through {sign,exp,mant[22:0]}, flags 0, -> DONE.
//    3 mant[24]=1 & exp==254: result {sign,8'hFF,23'b0}, out_overflow=1, -> DONE.
//    4 mant[24]=1: mant>>=1 (LSB dropped, truncation), exp+=1, stay NORM.
//    5 mant[23]=1: result {sign,exp,mant[22:0]}, flags 0, -> DONE.
//    6 exp==1: denormal result {sign,8'h00,mant[22:0]}, out_underflow=1, -> DONE.
//    7 else: mant<<=1, exp-=1, stay NORM.
//  - Latency accept->out_valid: 2 cycles normalised; +1 per shift; worst case 25 (mant=1).
//  - DONE: out_result/flags stable, out_valid=1 until out_ready=1; that edge -> IDLE,
//    out_valid drops. in_valid during NORM/DONE ignored (in_ready=0).
//  - No rounding: truncation only. Exponent arithmetic EXP_W+1 bits internally; step rules
//    guarantee exp stays in 1..254 during NORM.
//  - Flags cleared on each accept; mutually exclusive.
// STRUCTURE
//  - fp_pkg: EXP_W, FRAC_W, BIAS=127, EXP_MAX=254, EXP_SPECIAL=255, state enum
//    {IDLE,NORM,DONE}, function pack(sign,exp,frac) -> 32-bit word.
//  - Sub-module fp_norm_step: combinational single-step decision (action code, next mant,
//    next exp, flags). Top holds FSM, registers and handshakes.
// TESTING
//  1 sign=0 exp=127 mant=25'h0800000 -> 32'h3F800000, 2 cycles, flags 0.
//  2 sign=0 exp=127 mant=25'h1000000 -> 32'h40000000, 3 cycles (one right shift).
//  3 sign=0 exp=130 mant=25'h0200000 -> 32'h40000000, 4 cycles (two left shifts).
//  4 sign=1 exp=254 mant=25'h1000000 -> 32'hFF800000, out_overflow=1.
//  5 sign=0 exp=3 mant=25'h0000001 -> 32'h00000004, out_underflow=1, 4 cycles.
//  6 sign=1 mant=0 -> 32'h80000000; hold out_ready=0 10 cycles -> result stable;
//    then rst_n pulse mid-NORM -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub normalise-and-pack back end.
// Contents: field widths, exponent limits, the FSM state and step-action
// enums, and pack(), which assembles an IEEE-754 binary32 word from its fields.
package fp_pkg;

   localparam int EXP_W       = 8;
   localparam int FRAC_W      = 23;
   localparam int BIAS        = 127;
   localparam int EXP_MAX     = 254;
   localparam int EXP_SPECIAL = 255;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DONE
   } state_e;

   // Outcome of one normalisation step: finished, or shift right/left and go again.
   typedef enum logic [1:0] {
      ACT_DONE,
      ACT_SHR,
      ACT_SHL
   } norm_act_e;

   function automatic logic [31:0] pack(input logic              sign,
                                        input logic [EXP_W-1:0]  exp,
                                        input logic [FRAC_W-1:0] frac);
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/fp_norm_step.sv
// Combinational single-step normalisation decision.
// Given the current sign, exponent and mantissa, this module decides on one of
// three actions. It either finishes with a packed result and flags, shifts the
// mantissa right and increments the exponent, or shifts the mantissa left and
// decrements the exponent.
// Ports:
//   sign_i     result sign
//   exp_i      working exponent, one guard bit wider than the field
//   mant_i     working mantissa {carry, hidden, fraction}
//   special_i  operand exponent was 0 or all-ones at accept (pass-through)
//   act_o      norm_act_e code for this step
//   mant_o     mantissa for the next step (valid when shifting)
//   exp_o      exponent for the next step (valid when shifting)
//   result_o   packed word (valid when act_o == ACT_DONE)
//   ovf_o      result saturated to infinity
//   unf_o      result is denormal
module fp_norm_step
   import fp_pkg::*;
#(
   parameter int EXP_W  = fp_pkg::EXP_W,
   parameter int FRAC_W = fp_pkg::FRAC_W
) (
   input  logic              sign_i,
   input  logic [EXP_W:0]    exp_i,
   input  logic [FRAC_W+1:0] mant_i,
   input  logic              special_i,
   output logic [1:0]        act_o,
   output logic [FRAC_W+1:0] mant_o,
   output logic [EXP_W:0]    exp_o,
   output logic [31:0]       result_o,
   output logic              ovf_o,
   output logic              unf_o
);

   localparam logic [EXP_W:0]   EXP_TOP  = (EXP_W+1)'(EXP_MAX);
   localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W+1)'(1);
   localparam logic [EXP_W-1:0] EXP_INF  = EXP_W'(EXP_SPECIAL);
   localparam logic [EXP_W-1:0] EXP_ZERO = '0;
   localparam logic [FRAC_W-1:0] FRAC_ZERO = '0;

   logic carry;
   logic hidden;
   logic [FRAC_W-1:0] frac;

   assign carry  = mant_i[FRAC_W+1];
   assign hidden = mant_i[FRAC_W];
   assign frac   = mant_i[FRAC_W-1:0];

   // The order of tests matters: zero beats pass-through, and an overflowing
   // carry must be caught before the plain right-shift case.
   always_comb begin
      act_o    = ACT_DONE;
      mant_o   = mant_i;
      exp_o    = exp_i;
      result_o = '0;
      ovf_o    = 1'b0;
      unf_o    = 1'b0;
      if (mant_i == '0) begin
         result_o = pack(sign_i, EXP_ZERO, FRAC_ZERO);
      end else if (special_i) begin
         result_o = pack(sign_i, exp_i[EXP_W-1:0], frac);
      end else if (carry && (exp_i == EXP_TOP)) begin
         result_o = pack(sign_i, EXP_INF, FRAC_ZERO);
         ovf_o    = 1'b1;
      end else if (carry) begin
         // Truncating right shift: the dropped LSB is simply lost.
         act_o  = ACT_SHR;
         mant_o = mant_i >> 1;
         exp_o  = exp_i + EXP_ONE;
      end else if (hidden) begin
         result_o = pack(sign_i, exp_i[EXP_W-1:0], frac);
      end else if (exp_i == EXP_ONE) begin
         // Cannot go below the smallest normal exponent; emit as denormal.
         result_o = pack(sign_i, EXP_ZERO, frac);
         unf_o    = 1'b1;
      end else begin
         act_o  = ACT_SHL;
         mant_o = mant_i << 1;
         exp_o  = exp_i - EXP_ONE;
      end
   end

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalise-and-pack back end of the single-precision FP add/sub datapath.
// This block accepts the raw fraction-adder result and normalises it one bit
// per cycle. It then presents the packed binary32 word with overflow and
// underflow flags. Only one operand is in flight at a time.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       operand valid
//   in_ready       block can accept an operand (IDLE only)
//   in_sign        result sign
//   in_exp         biased exponent before normalisation
//   in_mant        {carry, hidden, fraction} unsigned magnitude
//   out_valid      packed result valid (DONE only)
//   out_ready      consumer takes the result
//   out_result     {sign, exp, frac}
//   out_overflow   result saturated to +/-inf
//   out_underflow  result denormal
module fp_normalize_pack
   import fp_pkg::*;
#(
   parameter int EXP_W  = fp_pkg::EXP_W,
   parameter int FRAC_W = fp_pkg::FRAC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [FRAC_W+1:0] in_mant,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_result,
   output logic              out_overflow,
   output logic              out_underflow
);

   localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(EXP_SPECIAL);

   state_e            state_q, state_d;
   logic              sign_q, sign_d;
   logic [EXP_W:0]    exp_q, exp_d;
   logic [FRAC_W+1:0] mant_q, mant_d;
   logic              special_q, special_d;
   logic [31:0]       result_q, result_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic [1:0]        step_act;
   logic [FRAC_W+1:0] step_mant;
   logic [EXP_W:0]    step_exp;
   logic [31:0]       step_result;
   logic              step_ovf;
   logic              step_unf;

   fp_norm_step #(
      .EXP_W  (EXP_W),
      .FRAC_W (FRAC_W)
   ) u_step (
      .sign_i    (sign_q),
      .exp_i     (exp_q),
      .mant_i    (mant_q),
      .special_i (special_q),
      .act_o     (step_act),
      .mant_o    (step_mant),
      .exp_o     (step_exp),
      .result_o  (step_result),
      .ovf_o     (step_ovf),
      .unf_o     (step_unf)
   );

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      mant_d    = mant_q;
      special_d = special_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d    = in_sign;
               exp_d     = {1'b0, in_exp};
               mant_d    = in_mant;
               // Zero/all-ones exponents are decided once, from the operand as accepted.
               special_d = (in_exp == '0) || (in_exp == EXP_ALL1);
               ovf_d     = 1'b0;
               unf_d     = 1'b0;
               state_d   = NORM;
            end
         end
         NORM: begin
            if (step_act == ACT_DONE) begin
               result_d = step_result;
               ovf_d    = step_ovf;
               unf_d    = step_unf;
               state_d  = DONE;
            end else begin
               mant_d = step_mant;
               exp_d  = step_exp;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         mant_q    <= '0;
         special_q <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         mant_q    <= mant_d;
         special_q <= special_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == DONE);
   assign out_result    = result_q;
   assign out_overflow  = ovf_q;
   assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
module tb_fp_normalize_pack;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [24:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      int          lat;
   } exp_t;

   exp_t sb[$];

   fp_normalize_pack dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_exp        (in_exp),
      .in_mant       (in_mant),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv)
      else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one operand, wait for its result, compare against the scoreboard
   // entry and complete the output handshake after 'hold' stall cycles.
   task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                         input logic [24:0] m, input logic [31:0] res,
                         input logic ovf, input logic unf, input int lat, input int hold);
      exp_t want;
      exp_t got;
      int   cyc;
      want.res = res;
      want.ovf = ovf;
      want.unf = unf;
      want.lat = lat;
      sb.push_back(want);
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      in_valid = 1'b0;
      in_mant  = '0;
      in_exp   = '0;
      check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      got = sb.pop_front();
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".latency"}, 32'(cyc), 32'(got.lat));
      check({tag, ".result"}, out_result, got.res);
      check({tag, ".ovf"}, 32'(out_overflow), 32'(got.ovf));
      check({tag, ".unf"}, 32'(out_underflow), 32'(got.unf));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_result"}, out_result, got.res);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
      check({tag, ".back_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_sign      = 1'b0;
      in_exp       = '0;
      in_mant      = '0;
      out_ready    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.result", out_result, 32'h0);
      check("rst.flags", {30'd0, out_overflow, out_underflow}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("t1_norm",      1'b0, 8'd127, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 2, 0);
      run_op("t2_shr",       1'b0, 8'd127, 25'h1000000, 32'h40000000, 1'b0, 1'b0, 3, 0);
      run_op("t3_shl2",      1'b0, 8'd130, 25'h0200000, 32'h40000000, 1'b0, 1'b0, 4, 0);
      run_op("t4_ovf",       1'b1, 8'd254, 25'h1000000, 32'hFF800000, 1'b1, 1'b0, 2, 0);
      run_op("t5_unf",       1'b0, 8'd3,   25'h0000001, 32'h00000004, 1'b0, 1'b1, 4, 0);
      run_op("t6_zero_hold", 1'b1, 8'd90,  25'h0000000, 32'h80000000, 1'b0, 1'b0, 2, 10);
      run_op("t7_pass255",   1'b0, 8'd255, 25'h0400001, 32'h7FC00001, 1'b0, 1'b0, 2, 0);
      run_op("t8_pass0",     1'b1, 8'd0,   25'h1800005, 32'h80000005, 1'b0, 1'b0, 2, 0);
      run_op("t9_worst",     1'b0, 8'd127, 25'h0000001, 32'h34000000, 1'b0, 1'b0, 25, 0);
      run_op("t10_trunc",    1'b0, 8'd100, 25'h1FFFFFF, 32'h32FFFFFF, 1'b0, 1'b0, 3, 0);
      run_op("t11_to254",    1'b0, 8'd253, 25'h1000000, 32'h7F000000, 1'b0, 1'b0, 3, 0);
      run_op("t12_ovfpos",   1'b0, 8'd254, 25'h1FFFFFF, 32'h7F800000, 1'b1, 1'b0, 2, 0);
      run_op("t13_unf_e1",   1'b1, 8'd1,   25'h0400000, 32'h80400000, 1'b0, 1'b1, 2, 0);

      // Abort a long normalisation with an asynchronous reset pulse.
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 8'd127;
      in_mant  = 25'h0000001;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("abort.busy", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("abort.out_valid", 32'(out_valid), 32'd0);
      check("abort.in_ready", 32'(in_ready), 32'd1);
      check("abort.result", out_result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("t14_after_rst", 1'b1, 8'd127, 25'h0800000, 32'hBF800000, 1'b0, 1'b0, 2, 0);

      check("sb.empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
